// File: rtl/prime_imc_mm_arbiter.sv
// prime_imc_mm_arbiter
//   Two-requester Avalon-MM arbiter in front of the shared IMC datapath.
//   Requester 0 is the NIOS bridge, requester 1 is the PROM sequencer.
//   At most one transaction is outstanding. Arbitration takes one cycle in
//   IDLE. Ties go round-robin against the last completed owner.
//
// Configuration macro:
//   PRIME_ARB_FIXED_PRIORITY_EN - when defined, requester 0 always wins ties.
//
// Ports:
//   sys_clk_in, sys_reset_in       clock, synchronous active-high reset
//   m0_mm_* / m1_mm_*              requester command in, response out
//   IMC_mm_*                       command out to the datapath, response in
//   grant_owner_out                index of the current/last granted requester
module prime_imc_mm_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  sys_clk_in,
  input  logic                  sys_reset_in,
  // Requester 0
  input  logic [ADDR_WIDTH-1:0] m0_mm_address_in,
  input  logic [DATA_WIDTH-1:0] m0_mm_writedata_in,
  input  logic                  m0_mm_write_in,
  input  logic                  m0_mm_read_in,
  output logic                  m0_mm_waitrequest_out,
  output logic [DATA_WIDTH-1:0] m0_mm_readdata_out,
  output logic                  m0_mm_readdatavalid_out,
  // Requester 1
  input  logic [ADDR_WIDTH-1:0] m1_mm_address_in,
  input  logic [DATA_WIDTH-1:0] m1_mm_writedata_in,
  input  logic                  m1_mm_write_in,
  input  logic                  m1_mm_read_in,
  output logic                  m1_mm_waitrequest_out,
  output logic [DATA_WIDTH-1:0] m1_mm_readdata_out,
  output logic                  m1_mm_readdatavalid_out,
  // Shared datapath
  output logic [ADDR_WIDTH-1:0] IMC_mm_address_out,
  output logic [DATA_WIDTH-1:0] IMC_mm_writedata_out,
  output logic                  IMC_mm_write_out,
  output logic                  IMC_mm_read_out,
  input  logic                  IMC_mm_waitrequest_in,
  input  logic [DATA_WIDTH-1:0] IMC_mm_readdata_in,
  input  logic                  IMC_mm_readdatavalid_in,
  // Status
  output logic                  grant_owner_out
);

  typedef enum logic [1:0] {StIdle, StGrant, StWaitRd} state_e;

  state_e r_state, w_state_next;
  logic   r_owner, w_owner_next;
  logic   r_last_grant, w_last_grant_next;

  logic                  w_req0, w_req1, w_pick;
  logic [ADDR_WIDTH-1:0] w_own_addr;
  logic [DATA_WIDTH-1:0] w_own_wdata;
  logic                  w_own_write, w_own_read;

  assign w_req0 = m0_mm_read_in | m0_mm_write_in;
  assign w_req1 = m1_mm_read_in | m1_mm_write_in;

  // Arbitration choice, only consumed in IDLE.
  always_comb begin
    w_pick = 1'b0;
`ifdef PRIME_ARB_FIXED_PRIORITY_EN
    w_pick = w_req0 ? 1'b0 : 1'b1;
`else
    if (w_req0 && w_req1) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = w_req1;
    end
`endif
  end

  // Owner's command; a simultaneous read is masked so only the write goes out.
  always_comb begin
    w_own_addr  = r_owner ? m1_mm_address_in   : m0_mm_address_in;
    w_own_wdata = r_owner ? m1_mm_writedata_in : m0_mm_writedata_in;
    w_own_write = r_owner ? m1_mm_write_in     : m0_mm_write_in;
    w_own_read  = (r_owner ? m1_mm_read_in : m0_mm_read_in) & ~w_own_write;
  end

  // Next-state logic.
  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_grant_next = r_last_grant;
    unique case (r_state)
      StIdle: begin
        if (w_req0 || w_req1) begin
          w_owner_next = w_pick;
          w_state_next = StGrant;
        end
      end
      StGrant: begin
        if (!w_own_write && !w_own_read) begin
          // Owner withdrew its request: abandon without completion.
          w_state_next = StIdle;
        end else if (!IMC_mm_waitrequest_in) begin
          if (w_own_write) begin
            w_state_next      = StIdle;
            w_last_grant_next = r_owner;
          end else begin
            w_state_next = StWaitRd;
          end
        end
      end
      StWaitRd: begin
        if (IMC_mm_readdatavalid_in) begin
          w_state_next      = StIdle;
          w_last_grant_next = r_owner;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output steering.
  always_comb begin
    IMC_mm_address_out      = '0;
    IMC_mm_writedata_out    = '0;
    IMC_mm_write_out        = 1'b0;
    IMC_mm_read_out         = 1'b0;
    m0_mm_waitrequest_out   = 1'b1;
    m1_mm_waitrequest_out   = 1'b1;
    m0_mm_readdata_out      = '0;
    m1_mm_readdata_out      = '0;
    m0_mm_readdatavalid_out = 1'b0;
    m1_mm_readdatavalid_out = 1'b0;
    if (r_state == StGrant) begin
      IMC_mm_address_out   = w_own_addr;
      IMC_mm_writedata_out = w_own_wdata;
      IMC_mm_write_out     = w_own_write;
      IMC_mm_read_out      = w_own_read;
      if (r_owner) begin
        m1_mm_waitrequest_out = IMC_mm_waitrequest_in;
      end else begin
        m0_mm_waitrequest_out = IMC_mm_waitrequest_in;
      end
    end else if (r_state == StWaitRd) begin
      if (r_owner) begin
        m1_mm_readdata_out      = IMC_mm_readdata_in;
        m1_mm_readdatavalid_out = IMC_mm_readdatavalid_in;
      end else begin
        m0_mm_readdata_out      = IMC_mm_readdata_in;
        m0_mm_readdatavalid_out = IMC_mm_readdatavalid_in;
      end
    end
  end

  assign grant_owner_out = r_owner;

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge sys_clk_in) begin
    if (sys_reset_in) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_grant <= w_last_grant_next;
    end
  end

endmodule

// File: doc/prime_imc_mm_arbiter.md
PRIME_IMC_MM_ARBITER -- requirements
Module: prime_imc_mm_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data width of all ports.
REQ-003 The block SHALL have a port sys_clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have a port sys_reset_in, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have ports m0_mm_address_in, m0_mm_writedata_in, m0_mm_write_in and m0_mm_read_in, inputs, ADDR_WIDTH/DATA_WIDTH/1/1 bits: requester 0 (NIOS bridge) command.
REQ-006 The block SHALL have ports m0_mm_waitrequest_out, m0_mm_readdata_out and m0_mm_readdatavalid_out, outputs, 1/DATA_WIDTH/1 bits: requester 0 response.
REQ-007 The block SHALL have ports m1_mm_* identical to REQ-005/006: requester 1 (PROM sequencer).
REQ-008 The block SHALL have ports IMC_mm_address_out, IMC_mm_writedata_out, IMC_mm_write_out and IMC_mm_read_out, outputs: command to the shared IMC datapath.
REQ-009 The block SHALL have ports IMC_mm_waitrequest_in, IMC_mm_readdata_in and IMC_mm_readdatavalid_in, inputs: datapath response.
REQ-010 The block SHALL have a port grant_owner_out, output, 1 bit: index of the current/last granted requester.

Function
REQ-011 The FSM SHALL have states IDLE, GRANT and WAIT_RD, with one outstanding transaction maximum.
REQ-012 In IDLE, req_i = mi_read | mi_write; if any req is high, the block SHALL register a grant and enter GRANT next cycle (1-cycle arbitration latency).
REQ-013 Round-robin: with both requesting, the block SHALL grant the requester not equal to last_grant; with one requesting, it SHALL grant that one.
REQ-014 In GRANT, IMC_mm_* command outputs SHALL equal the owner's inputs combinationally; owner waitrequest SHALL equal IMC_mm_waitrequest_in.
REQ-015 The non-owner, and both requesters in IDLE/WAIT_RD, SHALL see waitrequest=1.
REQ-016 In GRANT with waitrequest_in=0: a write SHALL complete and the FSM SHALL return to IDLE; a read SHALL move the FSM to WAIT_RD.
REQ-017 If the owner drops its request while in GRANT (protocol violation), the block SHALL return to IDLE with no command issued.
REQ-018 If the owner asserts read and write together, the block SHALL forward the write only and mask the read.
REQ-019 In WAIT_RD, IMC_mm_readdatavalid_in/readdata_in SHALL route combinationally to the owner only; on valid, the FSM SHALL go to IDLE, and last_grant SHALL update on every completion.
REQ-020 The non-owner readdatavalid SHALL be 0 always; readdatavalid_in arriving in IDLE/GRANT SHALL be discarded.
REQ-021 A back-to-back request from the same master SHALL pass through IDLE (min 1 idle cycle between transfers).
REQ-022 Outside GRANT, IMC_mm_write_out and IMC_mm_read_out SHALL be 0, and address/writedata SHALL hold 0.

Reset
REQ-023 On sys_reset_in=1 at a clock edge: state=IDLE, last_grant=1 (so m0 wins first tie), grant_owner_out=0, all waitrequest_out=1, all readdatavalid_out=0, readdata_out=0, IMC read/write=0.
REQ-024 Reset mid-transaction SHALL abandon it; a late readdatavalid_in after reset SHALL be discarded per REQ-020.

Configuration
REQ-025 Macro PRIME_ARB_FIXED_PRIORITY_EN, when defined, SHALL make requester 0 always win ties (last_grant ignored); when undefined, round-robin per REQ-013 applies.

Verification
REQ-026 Single write: m0 write addr 0x012 data 0xDEADBEEF, IMC waitrequest low -> IMC write seen 1 cycle later with same addr/data; m0 waitrequest low for exactly 1 cycle.
REQ-027 Read latency: m1 read addr 0x1FF, datapath returns 0x00C0FFEE 3 cycles after accept -> m1 readdatavalid=1 with 0x00C0FFEE; m0 readdatavalid stays 0.
REQ-028 Contention: m0 and m1 both write continuously for 8 transfers -> grants alternate 0,1,0,1...; with PRIME_ARB_FIXED_PRIORITY_EN defined -> all 8 grants go to m0.
REQ-029 Stall: IMC waitrequest held high 5 cycles in GRANT -> owner command stable and held; non-owner waitrequest=1 throughout; exactly one IMC write accepted.
REQ-030 Reset mid-read: assert reset in WAIT_RD, then inject readdatavalid_in -> no readdatavalid_out on either port; all outputs at REQ-023 values.
